// File: rtl/decoder_pkg.sv
// Shared types and helpers for the registered N-to-2^N select decoder.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package decoder_pkg;

   // Widest supported address; the select bus can be at most 2^MAX_N lines.
   localparam int MAX_N = 6;
   localparam int MAX_M = 1 << MAX_N;

   // Value of the mode input sampled together with an address load.
   localparam logic MODE_DECODE = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      SCAN   = 2'd2
   } state_t;

   // One-hot of idx over 2^n lines, returned at the maximum width.
   // Bits at or above 2^n are always clear, so callers can truncate safely.
   function automatic logic [MAX_M-1:0] onehot(input logic [MAX_N-1:0] idx,
                                               input int n);
      logic [MAX_M-1:0] r;
      r = '0;
      for (int i = 0; i < MAX_M; i++) begin
         r[i] = (i == int'(idx)) && (i < (1 << n));
      end
      return r;
   endfunction

endpackage

// File: rtl/decoder_nto2n_comb.sv
// Combinational N-to-2^N one-hot decoder with active-high enable.
// Latency: zero cycles, purely combinational.
// Backpressure: none; output follows inputs continuously.
module decoder_nto2n_comb
   import decoder_pkg::*;
#(
   parameter int N = 2
)
(
   input  logic [N-1:0]      sel,
   input  logic              en,
   output logic [(2**N)-1:0] y
);

   localparam int M = 2**N;

   // Select line sel goes high when enabled; everything low otherwise.
   always_comb begin
      y = '0;
      if (en) begin
         y = M'(onehot(MAX_N'(sel), N));
      end
   end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered one-hot select: holds a decoded address or walks a one-hot scan.
// Latency: a load or step edge updates D right after that edge; en gates D combinationally.
// Backpressure: addr_ready drops while scanning or while stop is asserted.
module decoder_nto2n_seq
   import decoder_pkg::*;
#(
   parameter int N         = 2,
   parameter int RESET_IDX = 0
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              addr_valid,
   output logic              addr_ready,
   input  logic [N-1:0]      addr,
   input  logic              mode,
   input  logic              step,
   input  logic              stop,
   output logic [(2**N)-1:0] D,
   output logic [N-1:0]      idx,
   output logic              busy,
   output logic              wrap
);

   localparam int M = 2**N;
   localparam logic [N-1:0] IDX_ONE  = N'(1);
   localparam logic [N-1:0] IDX_LAST = N'(M - 1);
   localparam logic [N-1:0] IDX_RST  = N'(RESET_IDX);

   // Reject illegal configurations at elaboration time.
   if (N < 1 || N > MAX_N) begin : g_bad_n
      $error("decoder_nto2n_seq: N must be in 1..%0d", MAX_N);
   end
   if (RESET_IDX < 0 || RESET_IDX >= M) begin : g_bad_reset_idx
      $error("decoder_nto2n_seq: RESET_IDX must be below 2**N");
   end

   state_t       state;
   state_t       state_nxt;
   logic [N-1:0] idx_nxt;
   logic         wrap_nxt;
   logic [M-1:0] d_reg;
   logic [M-1:0] d_nxt;
   logic         load;
   logic         sel_active;

   // A load is only possible outside SCAN, and stop always wins over a load.
   assign addr_ready = (state != SCAN) && !stop;
   assign load       = addr_valid && addr_ready;

   // Next state, next index and wrap pulse; stop has priority over load and step.
   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      wrap_nxt  = 1'b0;
      if (stop) begin
         state_nxt = IDLE;
      end else if (load) begin
         idx_nxt   = addr;
         state_nxt = (mode == MODE_SCAN) ? SCAN : DECODE;
      end else if ((state == SCAN) && step) begin
         // N-bit arithmetic wraps M-1 back to 0 naturally.
         idx_nxt  = idx + IDX_ONE;
         wrap_nxt = (idx == IDX_LAST);
      end
   end

   // The register image of D is computed from next-state values so it is
   // valid directly after the edge that loads or steps.
   assign sel_active = (state_nxt != IDLE);

   decoder_nto2n_comb #(
      .N (N)
   ) u_core (
      .sel (idx_nxt),
      .en  (sel_active),
      .y   (d_nxt)
   );

   // State, index, wrap pulse and select register with synchronous reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         idx   <= IDX_RST;
         wrap  <= 1'b0;
         d_reg <= '0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         wrap  <= wrap_nxt;
         d_reg <= d_nxt;
      end
   end

   // Output enable masks the bus only; the selection reappears with no delay.
   assign D    = en ? d_reg : '0;
   assign busy = (state != IDLE);

endmodule

// File: tb/tb_decoder_nto2n_seq.sv
module tb_decoder_nto2n_seq;

   logic clk;
   int   errors;
   int   checks;

   // N=2 instance, default reset index 0
   logic       rst2_n, en2, av2, ar2, mode2, step2, stop2, busy2, wrap2;
   logic [1:0] addr2, idx2;
   logic [3:0] d2;

   // N=3 instance, reset index 1
   logic       rst3_n, en3, av3, ar3, mode3, step3, stop3, busy3, wrap3;
   logic [2:0] addr3, idx3;
   logic [7:0] d3;

   decoder_nto2n_seq #(.N(2), .RESET_IDX(0)) u_dut2 (
      .clk(clk), .rst_n(rst2_n), .en(en2), .addr_valid(av2), .addr_ready(ar2),
      .addr(addr2), .mode(mode2), .step(step2), .stop(stop2),
      .D(d2), .idx(idx2), .busy(busy2), .wrap(wrap2)
   );

   decoder_nto2n_seq #(.N(3), .RESET_IDX(1)) u_dut3 (
      .clk(clk), .rst_n(rst3_n), .en(en3), .addr_valid(av3), .addr_ready(ar3),
      .addr(addr3), .mode(mode3), .step(step3), .stop(stop3),
      .D(d3), .idx(idx3), .busy(busy3), .wrap(wrap3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst2_n = 0; en2 = 1; av2 = 0; addr2 = 0; mode2 = 0; step2 = 0; stop2 = 0;
      rst3_n = 0; en3 = 1; av3 = 0; addr3 = 0; mode3 = 0; step3 = 0; stop3 = 0;
      tick(); tick();
      rst2_n = 1; rst3_n = 1;
      #1;
      checks++; if (d2 !== 4'b0000) begin errors++; $display("FAIL reset_d2: got %b want 0000", d2); end
      checks++; if (idx2 !== 2'd0) begin errors++; $display("FAIL reset_idx2: got %0d want 0", idx2); end
      checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL reset_busy2: got %b want 0", busy2); end
      checks++; if (wrap2 !== 1'b0) begin errors++; $display("FAIL reset_wrap2: got %b want 0", wrap2); end
      checks++; if (idx3 !== 3'd1) begin errors++; $display("FAIL reset_idx3: got %0d want 1", idx3); end
      tick();
      checks++; if (ar2 !== 1'b1) begin errors++; $display("FAIL reset_ready2: got %b want 1", ar2); end
      checks++; if (d2 !== 4'b0000) begin errors++; $display("FAIL reset_idle_d2: got %b want 0000", d2); end
   endtask

   task automatic test_decode_back_to_back();
      av3 = 1; addr3 = 3'd5; mode3 = 0;
      #1;
      checks++; if (ar3 !== 1'b1) begin errors++; $display("FAIL dec_ready: got %b want 1", ar3); end
      tick();
      checks++; if (d3 !== 8'b0010_0000) begin errors++; $display("FAIL dec_d5: got %b want 00100000", d3); end
      checks++; if (idx3 !== 3'd5) begin errors++; $display("FAIL dec_idx5: got %0d want 5", idx3); end
      checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL dec_busy: got %b want 1", busy3); end
      checks++; if (ar3 !== 1'b1) begin errors++; $display("FAIL dec_ready_in_decode: got %b want 1", ar3); end
      addr3 = 3'd2;
      tick();
      av3 = 0;
      checks++; if (d3 !== 8'b0000_0100) begin errors++; $display("FAIL dec_d2: got %b want 00000100", d3); end
      checks++; if (idx3 !== 3'd2) begin errors++; $display("FAIL dec_idx2: got %0d want 2", idx3); end
      step3 = 1;
      tick();
      step3 = 0;
      checks++; if (idx3 !== 3'd2) begin errors++; $display("FAIL dec_step_ignored: got %0d want 2", idx3); end
      checks++; if (d3 !== 8'b0000_0100) begin errors++; $display("FAIL dec_hold_d: got %b want 00000100", d3); end
   endtask

   task automatic test_scan_wrap();
      av2 = 1; addr2 = 2'd2; mode2 = 1;
      tick();
      av2 = 0; mode2 = 0;
      checks++; if (d2 !== 4'b0100) begin errors++; $display("FAIL scan_d_start: got %b want 0100", d2); end
      checks++; if (ar2 !== 1'b0) begin errors++; $display("FAIL scan_ready0: got %b want 0", ar2); end
      checks++; if (busy2 !== 1'b1) begin errors++; $display("FAIL scan_busy: got %b want 1", busy2); end
      step2 = 1; tick(); step2 = 0;
      checks++; if (d2 !== 4'b1000) begin errors++; $display("FAIL scan_d_3: got %b want 1000", d2); end
      checks++; if (wrap2 !== 1'b0) begin errors++; $display("FAIL scan_wrap_early: got %b want 0", wrap2); end
      checks++; if (ar2 !== 1'b0) begin errors++; $display("FAIL scan_ready1: got %b want 0", ar2); end
      step2 = 1; tick(); step2 = 0;
      checks++; if (d2 !== 4'b0001) begin errors++; $display("FAIL scan_d_0: got %b want 0001", d2); end
      checks++; if (idx2 !== 2'd0) begin errors++; $display("FAIL scan_idx_wrap: got %0d want 0", idx2); end
      checks++; if (wrap2 !== 1'b1) begin errors++; $display("FAIL scan_wrap_pulse: got %b want 1", wrap2); end
      step2 = 1; tick(); step2 = 0;
      checks++; if (d2 !== 4'b0010) begin errors++; $display("FAIL scan_d_1: got %b want 0010", d2); end
      checks++; if (wrap2 !== 1'b0) begin errors++; $display("FAIL scan_wrap_drop: got %b want 0", wrap2); end
      checks++; if (ar2 !== 1'b0) begin errors++; $display("FAIL scan_ready2: got %b want 0", ar2); end
      av2 = 1; addr2 = 2'd0; mode2 = 0;
      tick();
      av2 = 0;
      checks++; if (d2 !== 4'b0010) begin errors++; $display("FAIL scan_hold_refuse: got %b want 0010", d2); end
   endtask

   task automatic test_stop_beats_step();
      step2 = 1; tick(); tick(); step2 = 0;
      checks++; if (idx2 !== 2'd3) begin errors++; $display("FAIL stop_pre_idx: got %0d want 3", idx2); end
      step2 = 1; stop2 = 1;
      #1;
      checks++; if (ar2 !== 1'b0) begin errors++; $display("FAIL stop_ready_comb: got %b want 0", ar2); end
      tick();
      step2 = 0; stop2 = 0;
      #1;
      checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL stop_busy: got %b want 0", busy2); end
      checks++; if (d2 !== 4'b0000) begin errors++; $display("FAIL stop_d: got %b want 0000", d2); end
      checks++; if (idx2 !== 2'd3) begin errors++; $display("FAIL stop_idx: got %0d want 3", idx2); end
      checks++; if (wrap2 !== 1'b0) begin errors++; $display("FAIL stop_wrap: got %b want 0", wrap2); end
      checks++; if (ar2 !== 1'b1) begin errors++; $display("FAIL stop_ready: got %b want 1", ar2); end
      step2 = 1; tick(); step2 = 0;
      checks++; if (idx2 !== 2'd3) begin errors++; $display("FAIL idle_step_ignored: got %0d want 3", idx2); end
   endtask

   task automatic test_en_gate();
      av3 = 1; addr3 = 3'd7; mode3 = 0;
      tick();
      av3 = 0;
      checks++; if (d3 !== 8'b1000_0000) begin errors++; $display("FAIL en_d7: got %b want 10000000", d3); end
      en3 = 0;
      #1;
      checks++; if (d3 !== 8'h00) begin errors++; $display("FAIL en_low_comb: got %b want 0", d3); end
      tick();
      checks++; if (d3 !== 8'h00) begin errors++; $display("FAIL en_low_d: got %b want 0", d3); end
      checks++; if (idx3 !== 3'd7) begin errors++; $display("FAIL en_low_idx: got %0d want 7", idx3); end
      tick();
      checks++; if (busy3 !== 1'b1) begin errors++; $display("FAIL en_low_busy: got %b want 1", busy3); end
      en3 = 1;
      #1;
      checks++; if (d3 !== 8'b1000_0000) begin errors++; $display("FAIL en_return: got %b want 10000000", d3); end
   endtask

   task automatic test_reset_mid_scan();
      av3 = 1; addr3 = 3'd6; mode3 = 1;
      tick();
      av3 = 0; mode3 = 0;
      step3 = 1; tick();
      checks++; if (idx3 !== 3'd7) begin errors++; $display("FAIL rst_scan_pre: got %0d want 7", idx3); end
      rst3_n = 0;
      tick();
      rst3_n = 1; step3 = 0;
      #1;
      checks++; if (idx3 !== 3'd1) begin errors++; $display("FAIL rst_scan_idx: got %0d want 1", idx3); end
      checks++; if (d3 !== 8'h00) begin errors++; $display("FAIL rst_scan_d: got %b want 0", d3); end
      checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL rst_scan_busy: got %b want 0", busy3); end
      checks++; if (wrap3 !== 1'b0) begin errors++; $display("FAIL rst_scan_wrap: got %b want 0", wrap3); end
      checks++; if (ar3 !== 1'b1) begin errors++; $display("FAIL rst_scan_ready: got %b want 1", ar3); end
      tick();
      checks++; if (wrap3 !== 1'b0) begin errors++; $display("FAIL rst_scan_wrap_late: got %b want 0", wrap3); end
      av3 = 1; addr3 = 3'd3; mode3 = 0;
      tick();
      av3 = 0;
      checks++; if (d3 !== 8'b0000_1000) begin errors++; $display("FAIL rst_scan_reload: got %b want 00001000", d3); end
      av3 = 1; addr3 = 3'd0; stop3 = 1;
      tick();
      av3 = 0; stop3 = 0;
      #1;
      checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL stop_beats_load: got %b want 0", busy3); end
      checks++; if (idx3 !== 3'd3) begin errors++; $display("FAIL stop_load_idx: got %0d want 3", idx3); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      test_reset();
      test_decode_back_to_back();
      test_scan_wrap();
      test_stop_beats_step();
      test_en_gate();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/decoder_nto2n_seq.md
Name: decoder_nto2n_seq

Overview:
- Parametrised, registered successor to the team's 2-to-4 line decoder.
- Drives a one-hot select bus of 2^N lines.
- Two modes:
  - DECODE: hold one-hot of a loaded address.
  - SCAN: walking one-hot that advances on a step strobe and wraps.
- Sits between control logic and banked resources (row/bank selects, mux enables). Address loads use a valid/ready handshake.

Parameters:
- N, 2, address width. Legal range 1..6.
- M, 2**N, output line count. Derived localparam, not overridable.
- RESET_IDX, 0, index loaded into idx on reset. Must be < M.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- en  in  1  output enable; gates D only, state unaffected
- addr_valid  in  1  address/mode load request
- addr_ready  out  1  block can accept a load this cycle
- addr  in  N  address to decode / scan start index
- mode  in  1  sampled with a load: 0=DECODE, 1=SCAN
- step  in  1  SCAN only: advance one position
- stop  in  1  return to IDLE, clear selection
- D  out  M  one-hot select (all-zero in IDLE or when en=0)
- idx  out  N  current selected index (binary)
- busy  out  1  state != IDLE
- wrap  out  1  one-cycle pulse when scan wraps M-1 -> 0

Behaviour:
- Reset (rst_n=0 at rising clk edge):
  - state=IDLE, idx=RESET_IDX, wrap=0, D=0, busy=0.
  - addr_ready=1 from the first cycle after reset release.
  - Reset mid-scan or mid-decode aborts immediately; no wrap pulse is issued.
- FSM states: IDLE, DECODE, SCAN.
- addr_ready = (state != SCAN) && !stop. Combinational.
- Load: addr_valid && addr_ready at a clock edge. Takes effect that edge:
  - idx <= addr.
  - mode=0 -> DECODE; mode=1 -> SCAN.
- Output register:
  - d_reg = one-hot(idx) in DECODE/SCAN, 0 in IDLE.
  - D = en ? d_reg : 0 (combinational gate).
  - Latency: address at load edge -> D valid after that same edge, i.e. one cycle after addr_valid is presented.
- DECODE:
  - Holds the selection indefinitely.
  - A new load replaces it back-to-back with no IDLE gap.
  - step is ignored.
- SCAN:
  - On step=1: idx <= idx+1 mod M.
  - If idx==M-1 when stepped: idx <= 0 and wrap=1 for exactly the next cycle.
  - No step -> hold.
  - Loads are refused (addr_ready=0).
- stop=1 in any state: next state IDLE, d_reg=0, idx holds its last value.
  - stop beats step and load in the same cycle; no wrap is generated.
- IDLE: step ignored; idx holds.
- en=0:
  - D=0, but FSM, idx, wrap and handshake operate normally.
  - Re-asserting en shows the current selection immediately, with no latency.
- Width rules:
  - idx arithmetic is N bits with natural wrap.
  - one-hot generation is a shift of 1 by idx into M bits.
  - Exactly one D bit is set when en=1 and busy=1, for every N.
- wrap is registered and low in all cycles except the one following a wrapping step.

Decomposition:
- Package decoder_pkg:
  - state enum (IDLE, DECODE, SCAN).
  - mode constants MODE_DECODE=0, MODE_SCAN=1.
  - function onehot(idx, N) returning M bits.
- Sub-module: decoder_nto2n_comb, the combinational N-to-2^N one-hot core with enable.
  - Generalises the existing 1-to-2 / 2-to-4 decoders.
  - Instantiated once to produce d_reg's next value.

Test Plan:
1. Reset, then release with N=2: D=0000, idx=0, busy=0, wrap=0. addr_ready=1 in the first cycle after release.
2. N=3, load addr=5, mode=0, en=1:
   - next cycle D=0010_0000, idx=5, busy=1.
   - back-to-back load addr=2 -> D=0000_0100 with no zero cycle.
3. N=2 scan: load addr=2, mode=1, then 3 step pulses:
   - D=0100 -> 1000 -> 0001 -> 0010.
   - wrap high only in the cycle after the 3->0 step.
   - addr_ready=0 throughout.
4. N=2 SCAN at idx=3: assert step and stop together -> IDLE, D=0000, idx=3, no wrap pulse, addr_ready=1.
5. N=3 DECODE addr=7 with en toggled low for 2 cycles:
   - D=0 while en=0, with idx=7 and busy=1 unchanged.
   - D=1000_0000 in the same cycle en returns high.
6. N=3 SCAN mid-run, drive rst_n=0 for one edge: idx=RESET_IDX, D=0, IDLE, wrap=0. Loads are accepted on the next cycle.
